wb_copy_master: RTL

- Wishbone classic bus master (initiator) that copies a block of 32-bit words from a source address range to a destination address range.
- Sits on the initiator side of the same 32-bit, byte-select Wishbone bus the memory slaves respond on.
- Used for memory fill/copy and for the memory bring-up bench.
- Driven by a simple start/busy/done control interface; reports bus errors and timeouts.

---
 rtl/wb_copy_master_if.sv | 27 ++
 rtl/wb_copy_master.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_copy_master_if.sv
// Wishbone classic bus bundle (32-bit data, byte selects) used between
// the copy master and the memory slaves.
interface wb_copy_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [31:0]           DAT_I;
    logic [31:0]           DAT_O;
    logic [ADDR_WIDTH-1:0] ADR_O;
    logic                  CYC_O;
    logic                  STB_O;
    logic [3:0]            SEL_O;
    logic                  WE_O;
    logic                  ACK_I;
    logic                  ERR_I;

    // Initiator side: drives the cycle, samples data/ack/err.
    modport master (
        input  DAT_I, ACK_I, ERR_I,
        output DAT_O, ADR_O, CYC_O, STB_O, SEL_O, WE_O
    );

    // Target side: mirror of the initiator view.
    modport slave (
        output DAT_I, ACK_I, ERR_I,
        input  DAT_O, ADR_O, CYC_O, STB_O, SEL_O, WE_O
    );
endinterface

// File: rtl/wb_copy_master.sv
// Wishbone classic block-copy master: read a word from the source range,
// write it to the destination range, repeat len times. CYC_O is held for the
// whole copy; a bus error or an access timeout aborts the copy.
module wb_copy_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [LEN_WIDTH-1:0]  words_done,
    wb_copy_master_if.master      wb
);

    // Wide enough to hold TIMEOUT-1, the last legal wait count.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                state_q, state_d;

    // Copy bookkeeping
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    // Registered outputs
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [LEN_WIDTH-1:0]  words_done_q, words_done_d;
    logic [31:0]           dat_q, dat_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic [3:0]            sel_q, sel_d;
    logic                  we_q, we_d;

    // Helpers
    logic [ADDR_WIDTH-1:0] src_aligned;
    logic [ADDR_WIDTH-1:0] dst_aligned;
    logic [ADDR_WIDTH-1:0] src_next;
    logic [ADDR_WIDTH-1:0] dst_next;
    logic [LEN_WIDTH-1:0]  words_next;
    logic                  tmo_hit;

    assign src_aligned = {src_addr[ADDR_WIDTH-1:2], 2'b00};
    assign dst_aligned = {dst_addr[ADDR_WIDTH-1:2], 2'b00};
    assign src_next    = src_q + ADDR_WIDTH'(4);
    assign dst_next    = dst_q + ADDR_WIDTH'(4);
    assign words_next  = words_done_q + 1'b1;
    // This is the TIMEOUT-th cycle the current access has waited.
    assign tmo_hit     = (tmo_q == TW'(TIMEOUT - 1));

    // State and output registers; synchronous reset returns everything idle.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            tmo_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_addr_q   <= '0;
            words_done_q <= '0;
            dat_q        <= '0;
            adr_q        <= '0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            sel_q        <= 4'h0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            tmo_q        <= tmo_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_addr_q   <= err_addr_d;
            words_done_q <= words_done_d;
            dat_q        <= dat_d;
            adr_q        <= adr_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
        end
    end

    // Next-state and next-output logic; each access either completes,
    // errors, or times out, and an abort always routes through FINISH.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        tmo_d        = tmo_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        err_addr_d   = err_addr_q;
        words_done_d = words_done_q;
        dat_d        = dat_q;
        adr_d        = adr_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        sel_d        = sel_q;
        we_d         = we_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d      = 1'b0;
                    words_done_d = '0;
                    if (len != '0) begin
                        src_d      = src_aligned;
                        dst_d      = dst_aligned;
                        len_d      = len;
                        err_addr_d = '0;
                        tmo_d      = '0;
                        busy_d     = 1'b1;
                        cyc_d      = 1'b1;
                        stb_d      = 1'b1;
                        we_d       = 1'b0;
                        sel_d      = 4'hF;
                        adr_d      = src_aligned;
                        state_d    = S_READ;
                    end else begin
                        // Empty copy: no bus traffic, just the done pulse.
                        state_d = S_FINISH;
                    end
                end
            end

            S_READ, S_WRITE: begin
                if (wb.ERR_I || (!wb.ACK_I && tmo_hit)) begin
                    // Error wins over a simultaneous ACK; the failing word
                    // is not counted.
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    we_d       = 1'b0;
                    sel_d      = 4'h0;
                    error_d    = 1'b1;
                    err_addr_d = adr_q;
                    state_d    = S_FINISH;
                end else if (wb.ACK_I) begin
                    tmo_d = '0;
                    if (state_q == S_READ) begin
                        dat_d   = wb.DAT_I;
                        we_d    = 1'b1;
                        adr_d   = dst_q;
                        state_d = S_WRITE;
                    end else begin
                        words_done_d = words_next;
                        src_d        = src_next;
                        dst_d        = dst_next;
                        if (words_next == len_q) begin
                            cyc_d   = 1'b0;
                            stb_d   = 1'b0;
                            we_d    = 1'b0;
                            sel_d   = 4'h0;
                            state_d = S_FINISH;
                        end else begin
                            we_d    = 1'b0;
                            adr_d   = src_next;
                            state_d = S_READ;
                        end
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_addr   = err_addr_q;
    assign words_done = words_done_q;
    assign wb.DAT_O   = dat_q;
    assign wb.ADR_O   = adr_q;
    assign wb.CYC_O   = cyc_q;
    assign wb.STB_O   = stb_q;
    assign wb.SEL_O   = sel_q;
    assign wb.WE_O    = we_q;

endmodule
